// File: rtl/mod_counter.sv
// Modulo up/down counter with runtime terminal value, wrap/saturate modes and a terminal-count pulse.
// Define MOD_COUNTER_WRAP_CNT_EN to enable the wrap-event counter on wrap_cnt_sig.
module mod_counter #(
  parameter int WIDTH      = 11,
  parameter int WRAP_WIDTH = 8
) (
  input  logic                  clk_sig,
  input  logic                  reset_sig,
  input  logic                  en_sig,
  input  logic                  load_sig,
  input  logic [WIDTH-1:0]      load_val_sig,
  input  logic                  dir_sig,
  input  logic [WIDTH-1:0]      mod_sig,
  input  logic                  sat_sig,
  output logic [WIDTH-1:0]      counter_sig,
  output logic                  tc_sig,
  output logic [WRAP_WIDTH-1:0] wrap_cnt_sig
);

  logic             out_of_range;
  logic             at_terminal;
  logic             terminal_step;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] next_count;

  // An out-of-range count (mod_sig lowered underneath it) is treated like a boundary hit.
  always_comb begin
    out_of_range  = counter_sig > mod_sig;
    at_terminal   = dir_sig ? (counter_sig == mod_sig) : (counter_sig == '0);
    terminal_step = en_sig && !load_sig && (out_of_range || at_terminal);
    load_clamped  = (load_val_sig > mod_sig) ? mod_sig : load_val_sig;

    step_val = counter_sig;
    if (out_of_range)
      step_val = sat_sig ? mod_sig : '0;
    else if (dir_sig)
      step_val = at_terminal ? (sat_sig ? mod_sig : '0) : counter_sig + WIDTH'(1);
    else
      step_val = at_terminal ? (sat_sig ? '0 : mod_sig) : counter_sig - WIDTH'(1);

    next_count = counter_sig;
    if (load_sig)
      next_count = load_clamped;
    else if (en_sig)
      next_count = step_val;
  end

  always_ff @(posedge clk_sig or posedge reset_sig) begin
    if (reset_sig) begin
      counter_sig <= '0;
      tc_sig      <= 1'b0;
    end else begin
      counter_sig <= next_count;
      tc_sig      <= terminal_step;
    end
  end

`ifdef MOD_COUNTER_WRAP_CNT_EN
  logic [WRAP_WIDTH-1:0] wrap_cnt_q;

  // Only wrap-mode boundary crossings are events; saturating holds are not.
  always_ff @(posedge clk_sig or posedge reset_sig) begin
    if (reset_sig)
      wrap_cnt_q <= '0;
    else if (terminal_step && !sat_sig)
      wrap_cnt_q <= wrap_cnt_q + WRAP_WIDTH'(1);
  end

  assign wrap_cnt_sig = wrap_cnt_q;
`else
  assign wrap_cnt_sig = '0;
`endif

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, default 11, counter width in bits (legal 2..32).
REQ-002 Parameter WRAP_WIDTH, default 8, width of the wrap-event counter (legal 1..16).
REQ-003 clk_sig  input  1  sole clock, all state updates on rising edge.
REQ-004 reset_sig  input  1  asynchronous, active-high reset.
REQ-005 en_sig  input  1  count enable; one step per cycle while high.
REQ-006 load_sig  input  1  synchronous load strobe.
REQ-007 load_val_sig  input  WIDTH  value to load.
REQ-008 dir_sig  input  1  direction: 1 = up, 0 = down.
REQ-009 mod_sig  input  WIDTH  runtime terminal value (count range 0..mod_sig inclusive).
REQ-010 sat_sig  input  1  boundary mode: 1 = saturate, 0 = wrap.
REQ-011 counter_sig  output  WIDTH  registered count value.
REQ-012 tc_sig  output  1  registered terminal-count flag.
REQ-013 wrap_cnt_sig  output  WRAP_WIDTH  registered count of wrap events.

Function
REQ-014 Priority per cycle SHALL be reset > load_sig > en_sig > hold.
REQ-015 Load SHALL set counter_sig to min(load_val_sig, mod_sig) on the next edge, regardless of en_sig.
REQ-016 Load SHALL clear tc_sig and SHALL NOT change wrap_cnt_sig.
REQ-017 Up step, counter < mod_sig: counter_sig SHALL increment by 1.
REQ-018 Up step, counter == mod_sig: wrap mode -> 0; saturate mode -> hold at mod_sig.
REQ-019 Down step, counter > 0 and counter <= mod_sig: counter_sig SHALL decrement by 1.
REQ-020 Down step, counter == 0: wrap mode -> mod_sig; saturate mode -> hold at 0.
REQ-021 Out-of-range (counter > mod_sig after a runtime mod_sig change), any enabled step: wrap mode -> 0; saturate mode -> mod_sig; SHALL count as a terminal step.
REQ-022 Terminal step = enabled step taken from the terminal value (mod_sig when up, 0 when down) or from out-of-range.
REQ-023 tc_sig SHALL be 1 in the cycle after a terminal step and 0 after any non-terminal step, load or idle cycle (single-cycle pulse in wrap mode; stays high while en_sig is held at the boundary in saturate mode).
REQ-024 mod_sig == 0: every enabled step SHALL be terminal, counter_sig stays 0.
REQ-025 Arithmetic SHALL be unsigned WIDTH-bit, never overflowing past mod_sig; latency from any input to outputs is exactly one clock.
REQ-026 dir_sig, sat_sig and mod_sig SHALL be sampled every cycle; changes take effect on the next step with no pipeline flush.

Reset
REQ-027 reset_sig high SHALL immediately force counter_sig = 0, tc_sig = 0, wrap_cnt_sig = 0, independent of clk_sig.
REQ-028 Reset asserted mid-count SHALL discard in-flight load/step; the first step after deassertion starts from 0.

Configuration
REQ-029 Macro MOD_COUNTER_WRAP_CNT_EN SHALL control the wrap-event counter.
REQ-030 Defined: wrap_cnt_sig SHALL increment by 1 on every terminal step in wrap mode (not saturate mode), wrapping 2^WRAP_WIDTH-1 -> 0.
REQ-031 Undefined: wrap_cnt_sig SHALL be constant 0, no register inferred; port list unchanged.

Verification
REQ-032 WIDTH=11, mod_sig=5, up, wrap, en held 14 cycles after reset -> counter 1,2,3,4,5,0,1,...; tc_sig 1 only in the cycle counter shows 0 after 5; wrap_cnt_sig = 2 (macro on).
REQ-033 mod_sig=5, down, saturate, load_val_sig=2 then en 6 cycles -> 2,1,0,0,0,0,0; tc_sig high from the first held 0 onward; wrap_cnt_sig unchanged.
REQ-034 load_sig with load_val_sig=9, mod_sig=5 -> counter_sig = 5, tc_sig = 0; simultaneous load_sig and en_sig -> load wins.
REQ-035 counter at 7, mod_sig changed 10 -> 4, up, wrap, one step -> counter 0, tc_sig 1; same in saturate -> counter 4, tc_sig 1.
REQ-036 reset_sig pulsed between clock edges while counter = 3 -> outputs 0 before next edge; next enabled up step -> 1.
REQ-037 WRAP_WIDTH=2, 5 wraps -> wrap_cnt_sig 1,2,3,0,1; with macro undefined -> 0 throughout.
